// File: rtl/input_frame_parser.sv
// Per-port frame parser: pops header + payload words from an FWFT FIFO and forwards tagged payload.
// Defining PARSER_STATS_EN adds the stat_frames / stat_drops counter ports.
module input_frame_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_W     = 4,
    parameter int LEN_W      = 8,
    parameter int NUM_PORTS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PORT_W-1:0]     out_dest,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_pulse
`ifdef PARSER_STATS_EN
    ,
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_drops
`endif
);

    typedef enum logic [1:0] {ST_HDR, ST_PAY, ST_DROP} state_t;

    localparam logic [PORT_W:0]  NUM_PORTS_W = (PORT_W + 1)'(NUM_PORTS);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  first_q, first_d;
    logic [PORT_W-1:0]     dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PORT_W-1:0]     odest_q, odest_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [PORT_W-1:0]     hdr_dest;
    logic [LEN_W-1:0]      hdr_len;
    logic                  accept;

    assign hdr_dest = fifo_dout[PORT_W-1:0];
    assign hdr_len  = fifo_dout[PORT_W+LEN_W-1:PORT_W];
    assign accept   = valid_q && out_ready;

    // Headers and dropped words never touch the output register, so they may pop during a stall.
    assign fifo_rd_en = !fifo_empty && (state_q != ST_PAY || !valid_q || out_ready);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        rem_d   = rem_q;
        first_d = first_q;
        dest_d  = dest_q;
        data_d  = data_q;
        odest_d = odest_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = accept ? 1'b0 : valid_q;
        err_d   = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (fifo_rd_en) begin
                    if (hdr_len == '0) begin
                        err_d = 1'b1;
                    end else if ({1'b0, hdr_dest} >= NUM_PORTS_W) begin
                        state_d = ST_DROP;
                        rem_d   = hdr_len;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_PAY;
                        rem_d   = hdr_len;
                        first_d = 1'b1;
                        dest_d  = hdr_dest;
                    end
                end
            end
            ST_PAY: begin
                if (fifo_rd_en) begin
                    valid_d = 1'b1;
                    data_d  = fifo_dout;
                    odest_d = dest_q;
                    sop_d   = first_q;
                    eop_d   = (rem_q == LEN_ONE);
                    rem_d   = rem_q - LEN_ONE;
                    first_d = 1'b0;
                    if (rem_q == LEN_ONE) state_d = ST_HDR;
                end
            end
            ST_DROP: begin
                if (fifo_rd_en) begin
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_HDR;
            rem_q   <= '0;
            first_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            odest_q <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            odest_q <= odest_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_dest  = odest_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_valid = valid_q;
    assign err_pulse = err_q;

`ifdef PARSER_STATS_EN
    logic [15:0] frames_q;
    logic [15:0] drops_q;

    // A good frame is counted only once its last word has been accepted downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (accept && eop_q && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
            if (err_q && drops_q != 16'hFFFF)            drops_q  <= drops_q + 16'd1;
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_input_frame_parser.sv
// Scoreboard bench for input_frame_parser: a queue-based FIFO model feeds frames, a monitor
// compares every accepted beat against the expected-beat queue built from the frame rules.
module tb_input_frame_parser;

    localparam int DW = 32;
    localparam int PW = 5;
    localparam int LW = 8;
    localparam int NP = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [PW-1:0] dest;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_dest;
    logic          out_sop;
    logic          out_eop;
    logic          out_valid;
    logic          out_ready;
    logic          err_pulse;
`ifdef PARSER_STATS_EN
    logic [15:0]   stat_frames;
    logic [15:0]   stat_drops;
`endif

    input_frame_parser #(
        .DATA_WIDTH(DW),
        .PORT_W    (PW),
        .LEN_W     (LW),
        .NUM_PORTS (NP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_pulse  (err_pulse)
`ifdef PARSER_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_drops (stat_drops)
`endif
    );

    // FIFO contents and, per word, what it is: 0 header, 1 forwarded payload, 2 dropped payload.
    logic [DW-1:0] fifo_q[$];
    int            kind_q[$];
    beat_t         exp_q[$];
    int            acc_cyc[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int ready_mode = 0;     // 0 always ready, 1 toggling, 2 random
    bit rand_gaps = 0;
    int pop_budget = -1;    // -1 unlimited; otherwise FIFO looks empty once it reaches 0
    int err_seen = 0;
    int exp_err = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one frame becomes FIFO words plus the beats the arbiter should see.
    task automatic push_frame(input int dest, input int len);
        logic [DW-1:0] w;
        beat_t         b;
        w = $urandom;
        w[PW-1:0] = dest[PW-1:0];
        w[PW+LW-1:PW] = len[LW-1:0];
        fifo_q.push_back(w);
        kind_q.push_back(0);
        if (len == 0) begin
            exp_err++;
            exp_drops++;
            return;
        end
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            if (dest >= NP) begin
                kind_q.push_back(2);
            end else begin
                kind_q.push_back(1);
                b.data = w;
                b.dest = dest[PW-1:0];
                b.sop  = (i == 0);
                b.eop  = (i == len - 1);
                exp_q.push_back(b);
            end
        end
        if (dest >= NP) begin
            exp_err++;
            exp_drops++;
        end else begin
            exp_frames++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drain_in_time"}, 64'(n < 5000), 64'd1);
        check({name, "_err_pulses"}, 64'(err_seen), 64'(exp_err));
    endtask

    // FIFO / ready driver; also checks the pop strobe against the read rule every cycle.
    initial begin : driver
        bit      rd_prev;
        logic    exp_rd;
        int      head_kind;
        logic [DW-1:0] dummy_w;
        int      dummy_k;
        rd_prev    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        out_ready  = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_prev && fifo_q.size() > 0) begin
                dummy_w = fifo_q.pop_front();
                dummy_k = kind_q.pop_front();
                if (pop_budget > 0) pop_budget--;
            end
            fifo_empty = (fifo_q.size() == 0) || (pop_budget == 0) ||
                         (rand_gaps && $urandom_range(3) == 0);
            fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cycle[0];
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            if (rst) begin
                rd_prev = 1'b0;
            end else begin
                head_kind = (kind_q.size() > 0) ? kind_q[0] : 0;
                exp_rd = !fifo_empty && (head_kind != 1 || !out_valid || out_ready);
                check("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
                rd_prev = fifo_rd_en;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    initial begin : monitor
        beat_t e;
        beat_t prev;
        bit    prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (err_pulse) err_seen++;
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev.data));
                check("stall_tags", 64'({out_dest, out_sop, out_eop}),
                      64'({prev.dest, prev.sop, prev.eop}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_dest", 64'(out_dest), 64'(e.dest));
                    check("out_sop", 64'(out_sop), 64'(e.sop));
                    check("out_eop", 64'(out_eop), 64'(e.eop));
                    acc_cyc.push_back(cycle);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev.data = out_data;
            prev.dest = out_dest;
            prev.sop  = out_sop;
            prev.eop  = out_eop;
        end
    end

    initial begin : main
        int n;
        int dest;
        int len;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        check("rst_err", 64'(err_pulse), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_dest", 64'(out_dest), 64'd0);
`ifdef PARSER_STATS_EN
        check("rst_stats", 64'({stat_frames, stat_drops}), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two back-to-back frames, always ready: one idle slot per header only.
        acc_cyc.delete();
        push_frame(3, 4);
        push_frame(3, 4);
        drain("t1");
        check("t1_beats", 64'(acc_cyc.size()), 64'd8);
        if (acc_cyc.size() >= 8) begin
            check("t1_span_first", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
            check("t1_hdr_gap", 64'(acc_cyc[4] - acc_cyc[3]), 64'd2);
            check("t1_span_second", 64'(acc_cyc[7] - acc_cyc[4]), 64'd3);
        end

        // Toggling ready: stalls must hold the output and block payload pops.
        ready_mode = 1;
        push_frame(3, 4);
        drain("t2");

        // Zero-length header, then a single-word frame.
        ready_mode = 0;
        push_frame(1, 0);
        push_frame(1, 1);
        drain("t3");

        // Illegal destinations are consumed silently; last legal port still forwards.
        push_frame(20, 3);
        push_frame(5, 2);
        push_frame(16, 2);
        push_frame(15, 1);
        drain("t4");

        // FIFO runs dry after D1 and refills five cycles later.
        pop_budget = 3;
        push_frame(7, 4);
        n = 0;
        while (pop_budget != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("t5_words_pending", 64'(exp_q.size()), 64'd2);
        check("t5_idle_valid", 64'(out_valid), 64'd0);
        pop_budget = -1;
        drain("t5");

        // Maximum length frame.
        push_frame(2, 255);
        drain("t_maxlen");

        // Reset in the middle of a payload.
        push_frame(4, 6);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_payload", 64'(out_valid), 64'd1);
        rst = 1'b1;
        fifo_q.delete();
        kind_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_drops = 0;
        @(negedge clk);
        #3;
        check("t6_valid_cleared", 64'(out_valid), 64'd0);
`ifdef PARSER_STATS_EN
        check("t6_stats_cleared", 64'({stat_frames, stat_drops}), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_frame(20, 3);
        push_frame(6, 3);
        drain("t6");
`ifdef PARSER_STATS_EN
        check("t6_stat_frames", 64'(stat_frames), 64'd1);
        check("t6_stat_drops", 64'(stat_drops), 64'd1);
`endif

        // Randomized traffic with random backpressure and FIFO gaps.
        ready_mode = 2;
        rand_gaps = 1'b1;
        for (int f = 0; f < 40; f++) begin
            dest = ($urandom_range(3) == 0) ? $urandom_range(31, 16) : $urandom_range(15, 0);
            len  = ($urandom_range(6) == 0) ? 0 : $urandom_range(12, 1);
            push_frame(dest, len);
        end
        drain("rand");
`ifdef PARSER_STATS_EN
        check("final_stat_frames", 64'(stat_frames), 64'(exp_frames));
        check("final_stat_drops", 64'(stat_drops), 64'(exp_drops));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
